// File: rtl/md_defs.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package md_defs;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit. It computes the result when the op is accepted,
// holds it in pending registers, and commits it to HI/LO after a fixed latency.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic             p_we_q, p_we_d;

  logic signed [63:0] mul_s;
  logic [63:0]        mul_u;
  logic [31:0]        abs_a, abs_b, safe_b, safe_abs_b;
  logic [31:0]        uq, ur, sq_mag, sr_mag, sq, sr;

  // Signed division works on magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 with a zero remainder instead of relying on simulator overflow.
  always_comb begin
    mul_s      = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    mul_u      = {32'd0, A} * {32'd0, B};
    abs_a      = A[31] ? (~A + 32'd1) : A;
    abs_b      = B[31] ? (~B + 32'd1) : B;
    safe_b     = (B == 32'd0) ? 32'd1 : B;
    safe_abs_b = (B == 32'd0) ? 32'd1 : abs_b;
    uq         = A / safe_b;
    ur         = A % safe_b;
    sq_mag     = abs_a / safe_abs_b;
    sr_mag     = abs_a % safe_abs_b;
    sq         = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
    sr         = A[31] ? (~sr_mag + 32'd1) : sr_mag;
  end

  // NOTE: every _d gets its hold value first so no path through the case
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_we_d  = p_we_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (op)
            MD_MULT: begin
              {p_hi_d, p_lo_d} = mul_s;
              p_we_d  = 1'b1;
              count_d = MULT_LOAD;
              state_d = ST_BUSY;
            end
            MD_MULTU: begin
              {p_hi_d, p_lo_d} = mul_u;
              p_we_d  = 1'b1;
              count_d = MULT_LOAD;
              state_d = ST_BUSY;
            end
            MD_DIV: begin
              p_hi_d  = sr;
              p_lo_d  = sq;
              p_we_d  = (B != 32'd0);
              count_d = DIV_LOAD;
              state_d = ST_BUSY;
            end
            MD_DIVU: begin
              p_hi_d  = ur;
              p_lo_d  = uq;
              p_we_d  = (B != 32'd0);
              count_d = DIV_LOAD;
              state_d = ST_BUSY;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (count_q == '0) begin
          if (p_we_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the pending result
  // registers are reset too so an aborted operation can never leak into HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_we_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_we_q  <= p_we_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random traffic against
// a reference model built from 64-bit integer arithmetic and a latency counter.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  int          m_left;
  bit          m_commit;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: return (b == 32'd0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_left = 0; m_commit = 1'b0;
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_commit) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end else if (s) begin
      case (o)
        3'd0, 3'd1: begin
          {m_ph, m_pl} = ref_result(o, a, b);
          m_left = MULT_N; m_commit = 1'b1;
        end
        3'd2, 3'd3: begin
          {m_ph, m_pl} = ref_result(o, a, b);
          m_left = DIV_N; m_commit = (b != 32'd0);
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string where);
    check({where, "_busy"}, {31'd0, busy}, {31'd0, m_left > 0});
    check({where, "_hi"}, HI, m_hi);
    check({where, "_lo"}, LO, m_lo);
  endtask

  task automatic step(input logic s, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b);
    start = s; op = o; A = a; B = b;
    @(posedge clk);
    model_edge(s, o, a, b);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    check_all("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, holds, then releases.
  task automatic pulse_reset(input string where);
    #3 reset = 1'b0;
    model_clear();
    #1 check_all({where, "_async"});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_all({where, "_hold"});
    end
    #3 reset = 1'b1;
    #1 check_all({where, "_rel"});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all("por");
    #3 reset = 1'b1;

    // MULT / MULTU
    step(1'b1, 3'd0, 32'hFFFFFFFF, 32'h2);
    check("mult_busy_rise", {31'd0, busy}, 32'd1);
    idle(MULT_N);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFE);
    step(1'b1, 3'd1, 32'hFFFFFFFF, 32'h2);
    idle(MULT_N);
    check("multu_hi", HI, 32'h00000001);
    check("multu_lo", LO, 32'hFFFFFFFE);

    // DIV / DIVU including the overflow corner
    step(1'b1, 3'd2, 32'hFFFFFFF9, 32'd2);
    idle(DIV_N - 1);
    check("div_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    check("div_hi", HI, 32'hFFFFFFFF);
    check("div_lo", LO, 32'hFFFFFFFD);
    step(1'b1, 3'd3, 32'd7, 32'd2);
    idle(DIV_N);
    check("divu_hi", HI, 32'd1);
    check("divu_lo", LO, 32'd3);
    step(1'b1, 3'd2, 32'h80000000, 32'hFFFFFFFF);
    idle(DIV_N);
    check("divovf_hi", HI, 32'd0);
    check("divovf_lo", LO, 32'h80000000);

    // MTHI / MTLO, then divide by zero leaves them alone
    step(1'b1, 3'd4, 32'h12345678, 32'd0);
    check("mthi_hi", HI, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    step(1'b1, 3'd5, 32'h9ABCDEF0, 32'd0);
    check("mtlo_lo", LO, 32'h9ABCDEF0);
    step(1'b1, 3'd3, 32'd99, 32'd0);
    idle(DIV_N);
    check("div0_hi", HI, 32'h12345678);
    check("div0_lo", LO, 32'h9ABCDEF0);

    // Starts while busy are ignored; commit lands at the original edge
    step(1'b1, 3'd0, 32'd5, 32'd6);
    step(1'b1, 3'd5, 32'hDEADBEEF, 32'd0);
    step(1'b1, 3'd2, 32'd100, 32'd7);
    idle(MULT_N - 3);
    check("ign_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd30);

    // Back-to-back accept right after busy falls
    step(1'b1, 3'd1, 32'd3, 32'd4);
    idle(MULT_N);
    check("b2b_hi", HI, 32'd0);
    check("b2b_lo", LO, 32'd12);

    // Random traffic, including ops 6/7, zero divisors and starts during busy
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      step(1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), ra, rb);
    end
    pulse_reset("rnd_rst");
    idle(3);

    // Reset in the middle of a MULT aborts it
    step(1'b1, 3'd0, 32'd3, 32'd4);
    idle(2);
    pulse_reset("midop_rst");
    idle(MULT_N + 2);
    check("midop_no_commit_lo", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes forwarded GRF read data (rs/rt operands) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers.
- HI/LO values return to the GRF write port through MFHI/MFLO in WB.
- The hazard unit stalls D using `start` and `busy`.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for MULT/MULTU (>=1)
- DIV_CYCLES, 10, cycles `busy` stays high for DIV/DIVU (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  valid pulse for op; sampled on rising edge
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, others=no-op
- A  input  32  rs operand (forwarded GRF BUSA)
- B  input  32  rt operand (forwarded GRF BUSB)
- busy  output  1  long operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset: reset=0 forces, asynchronously, state=IDLE, count=0, busy=0, HI=0, LO=0, and pending result regs=0. Reset mid-operation aborts it; no commit follows release.
- States: IDLE, BUSY.
- IDLE accepting start, op in 0-3:
  - Latch the full result into pending regs {p_hi, p_lo} at that edge.
  - Load count with N-1 (N = MULT_CYCLES for 0/1, DIV_CYCLES for 2/3) and go to BUSY.
  - busy rises after that edge.
- BUSY: count decrements each edge. On the edge where count==0, HI<=p_hi, LO<=p_lo, go to IDLE, busy falls.
- Net timing: start sampled at edge k gives busy high for exactly N cycles, with HI/LO updated at edge k+N.
- MULT: signed 32x32 to 64; HI=prod[63:32], LO=prod[31:0]. MULTU: same, unsigned.
- DIV: signed, truncating toward zero; LO=quotient, HI=remainder with the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned; LO=quotient, HI=remainder.
- Divide by zero (B==0, op 2/3): runs the full DIV_CYCLES with busy, then commits nothing; HI/LO unchanged.
- MTHI/MTLO in IDLE: HI<=A or LO<=A at the start edge, no busy. Writes only the named register.
- In BUSY, start with any op is ignored. The hazard unit guarantees stall; the bench checks that the ignore holds.
- start with op 6/7: no effect in any state.
- Operands are sampled only at the start edge; later A/B changes have no effect.
- HI/LO are direct register outputs (no combinational path from A/B).

Decomposition:
- Shared package md_defs:
  - op encodings MD_MULT..MD_MTLO (3-bit localparams)
  - state encodings ST_IDLE/ST_BUSY
- No sub-module. The product/quotient logic is inline combinational feeding pending regs.
- A future iterative divider would become sub-module md_divider.

Test Plan:
- Reset: hold reset=0 for 3 cycles after random activity -> busy=0, HI=0, LO=0. Release -> values hold.
- MULT/MULTU:
  - MULT A=0xFFFFFFFF B=0x00000002 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV/DIVU:
  - DIV A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7 B=2 -> LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero, MTHI/MTLO, and busy-ignore:
  - Preset HI=0x12345678 (MTHI) and LO=0x9ABCDEF0 (MTLO) -> each updates next edge, busy stays 0.
  - DIVU B=0 -> busy 10 cycles, HI/LO unchanged.
  - During a MULT's busy, issue start MTLO A=0xDEADBEEF and start DIV -> both ignored; the MULT result commits at the original edge.
- Reset mid-op: MULT 3x4, assert reset after 2 busy cycles -> busy=0 and HI=LO=0 immediately (asynchronous), no commit after release.
- Back-to-back: start MULTU 3x4 on the cycle after busy falls -> accepted, HI=0, LO=12 five cycles later.
